// File: rtl/equiv_stim_checker.sv
// Equivalence stimulus/checker: LFSR vectors to golden and synthesized designs,
// latency-aligned compare with sticky/first/count results and a MISR over y_dut.
//
// state   | meaning
// IDLE    | waiting for start after reset
// PRIME   | stim forced to zero for one cycle, results cleared
// RUN     | one vector per cycle, k = 0..NUM_VEC-1
// DRAIN   | last vector held for LAT cycles while the valid pipe empties
// DONE    | results stable; start re-runs from PRIME
module equiv_stim_checker #(
  parameter int          IN_W       = 256,
  parameter int          OUT_W      = 119,
  parameter int          NUM_VEC    = 24,
  parameter int          LAT        = 1,
  parameter int          ZERO_EVERY = 0,
  parameter logic [31:0] SEED       = 32'h1EE62FE1,
  parameter logic [31:0] POLY       = 32'h80200003
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [IN_W-1:0]  stim,
  input  logic [OUT_W-1:0] y_ref,
  input  logic [OUT_W-1:0] y_dut,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [15:0]      first_idx,
  output logic [15:0]      mis_count,
  output logic [31:0]      signature
);
  localparam int NW = (IN_W + 31) / 32;
  localparam int NO = (OUT_W + 31) / 32;
  localparam int KW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;

  typedef enum logic [2:0] {S_IDLE, S_PRIME, S_RUN, S_DRAIN, S_DONE} state_t;
  typedef logic [NO*32-1:0] ypad_t;
  typedef logic [IN_W-1:0]  stim_t;

  state_t           state_q, state_d;
  logic [31:0]      lfsr_q [NW];
  logic [31:0]      lfsr_d [NW];
  logic [NW*32-1:0] lfsr_cat;
  logic [IN_W-1:0]  stim_q, stim_d;
  logic [KW-1:0]    k_q, k_d;
  logic [15:0]      z_q, z_d;
  logic [15:0]      drain_q, drain_d;
  logic [LAT-1:0]   pv_q, pv_d;
  logic [KW-1:0]    pk_q [LAT];
  logic [KW-1:0]    pk_d [LAT];
  logic             busy_q, busy_d, done_q, done_d, mis_q, mis_d;
  logic [15:0]      first_q, first_d, cnt_q, cnt_d;
  logic [31:0]      sig_q, sig_d, fold;
  ypad_t            y_pad;
  logic             zero_vec, sample_diff;

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    lfsr_step = {x[30:0], 1'b0} ^ (x[31] ? POLY : 32'h0);
  endfunction

  function automatic logic [31:0] lfsr_seed(input int i);
    lfsr_seed = SEED ^ (32'(i) * 32'h9E3779B9);
  endfunction

  always_comb begin
    state_d = state_q;
    stim_d  = stim_q;
    k_d     = k_q;
    z_d     = z_q;
    drain_d = drain_q;
    busy_d  = busy_q;
    done_d  = done_q;
    mis_d   = mis_q;
    first_d = first_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    for (int i = 0; i < NW; i++) lfsr_d[i] = lfsr_q[i];
    lfsr_cat = '0;
    for (int i = 0; i < NW; i++) lfsr_cat[i*32 +: 32] = lfsr_q[i];
    zero_vec = (ZERO_EVERY > 0) && (z_q == 16'(ZERO_EVERY - 1));
    y_pad = ypad_t'(y_dut);
    fold  = '0;
    for (int i = 0; i < NO; i++) fold = fold ^ y_pad[i*32 +: 32];
    sample_diff = (y_ref !== y_dut);

    // valid pipe: stage LAT-1 marks the edge at which y belongs to vector pk
    pv_d = pv_q << 1;
    pk_d[0] = k_q;
    for (int i = 1; i < LAT; i++) pk_d[i] = pk_q[i-1];

    if (pv_q[LAT-1]) begin
      sig_d = lfsr_step(sig_q) ^ fold;
      if (sample_diff) begin
        if (!mis_q) begin
          mis_d   = 1'b1;
          first_d = 16'(pk_q[LAT-1]);
        end
        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'h1;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_PRIME;
          stim_d  = '0;
          k_d     = '0;
          z_d     = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          mis_d   = 1'b0;
          first_d = 16'hFFFF;
          cnt_d   = '0;
          sig_d   = '0;
          for (int i = 0; i < NW; i++) lfsr_d[i] = lfsr_seed(i);
        end
      end
      S_PRIME: state_d = S_RUN;
      S_RUN: begin
        pv_d[0] = 1'b1;
        if (zero_vec) begin
          stim_d = '0;
        end else begin
          stim_d = stim_t'(lfsr_cat);
          for (int i = 0; i < NW; i++) lfsr_d[i] = lfsr_step(lfsr_q[i]);
        end
        if (ZERO_EVERY > 0) z_d = zero_vec ? 16'h0 : z_q + 16'h1;
        k_d = k_q + KW'(1);
        if (k_q == KW'(NUM_VEC - 1)) begin
          state_d = S_DRAIN;
          drain_d = 16'(LAT - 1);
        end
      end
      S_DRAIN: begin
        if (drain_q == 16'h0) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q - 16'h1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      stim_q  <= '0;
      k_q     <= '0;
      z_q     <= '0;
      drain_q <= '0;
      pv_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      first_q <= 16'hFFFF;
      cnt_q   <= '0;
      sig_q   <= '0;
      for (int i = 0; i < NW; i++) lfsr_q[i] <= lfsr_seed(i);
      for (int i = 0; i < LAT; i++) pk_q[i] <= '0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      k_q     <= k_d;
      z_q     <= z_d;
      drain_q <= drain_d;
      pv_q    <= pv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
      first_q <= first_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
      for (int i = 0; i < NW; i++) lfsr_q[i] <= lfsr_d[i];
      for (int i = 0; i < LAT; i++) pk_q[i] <= pk_d[i];
    end
  end

  assign stim      = stim_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign mismatch  = mis_q;
  assign first_idx = first_q;
  assign mis_count = cnt_q;
  assign signature = sig_q;
endmodule

// File: tb/tb_equiv_stim_checker.sv
// Bench for equiv_stim_checker: three instances (plain, zero-insert with LAT=3, long saturating run)
// checked by queue-based scoreboards fed from a vector-list reference model.
module tb_equiv_stim_checker;
  localparam int NA = 24;
  localparam int NB = 24;
  localparam int LB = 3;
  localparam int NC = 70000;
  localparam logic [31:0] SEED = 32'h1EE62FE1;
  localparam logic [31:0] POLY = 32'h80200003;

  typedef struct packed {
    logic        mis;
    logic [15:0] first;
    logic [15:0] cnt;
    logic [31:0] sig;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  function automatic void chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s", nm);
  endfunction

  function automatic logic [31:0] step(input logic [31:0] x);
    return {x[30:0], 1'b0} ^ (x[31] ? POLY : 32'h0);
  endfunction

  // stand-in golden function; any fixed function of stim works here
  function automatic logic [255:0] gold(input logic [255:0] s);
    return {128'h0, s[127:0] ^ s[255:128] ^ {s[120:0], 7'h0} ^ {3'h0, s[255:131]}};
  endfunction

  function automatic logic [255:0] plain_vec(input int k);
    logic [31:0] l [8];
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) l[i] = SEED ^ (32'(i) * 32'h9E3779B9);
    for (int j = 0; j <= k; j++) begin
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = l[i];
      for (int i = 0; i < 8; i++) l[i] = step(l[i]);
    end
    return v;
  endfunction

  // ---------------- instance A: defaults ----------------
  logic rst_a = 1'b1, start_a = 1'b0;
  logic [255:0] stim_a;
  logic [118:0] y_ref_a, y_dut_a, cur_mask_a;
  logic busy_a, done_a, mis_a;
  logic [15:0] first_a, cnt_a;
  logic [31:0] sig_a;
  logic [118:0] mask_a [NA];
  int c_a = 1000;
  bit go_a = 0, act_a = 0;
  logic [255:0] exp_stim_a [$];
  res_t res_qa [$];
  res_t e_a, last_a;

  always @(posedge clk) c_a <= go_a ? 0 : (c_a < 1000000 ? c_a + 1 : c_a);
  assign y_ref_a = 119'(gold(stim_a));
  always_comb begin
    cur_mask_a = '0;
    if (c_a >= 2 && c_a < NA + 2) cur_mask_a = mask_a[c_a-2];
  end
  assign y_dut_a = y_ref_a ^ cur_mask_a;

  equiv_stim_checker #(.IN_W(256), .OUT_W(119), .NUM_VEC(NA), .LAT(1), .ZERO_EVERY(0),
                       .SEED(SEED), .POLY(POLY)) u_a (
    .clk(clk), .rst(rst_a), .start(start_a), .stim(stim_a), .y_ref(y_ref_a), .y_dut(y_dut_a),
    .busy(busy_a), .done(done_a), .mismatch(mis_a), .first_idx(first_a), .mis_count(cnt_a),
    .signature(sig_a));

  // ---------------- instance B: ZERO_EVERY=4, LAT=3, y_dut one cycle late ----------------
  logic rst_bc = 1'b1, start_b = 1'b0;
  logic [255:0] stim_b, sb1, sb2, sb3;
  logic [118:0] y_ref_b, y_dut_b;
  logic busy_b, done_b, mis_b;
  logic [15:0] first_b, cnt_b;
  logic [31:0] sig_b;
  int c_b = 1000;
  bit go_b = 0, act_b = 0;
  logic [255:0] exp_stim_b [$];
  res_t res_qb [$];
  res_t e_b;

  always @(posedge clk) begin
    c_b <= go_b ? 0 : (c_b < 1000000 ? c_b + 1 : c_b);
    sb1 <= stim_b;
    sb2 <= sb1;
    sb3 <= sb2;
  end
  assign y_ref_b = 119'(gold(sb2));
  assign y_dut_b = 119'(gold(sb3));

  equiv_stim_checker #(.IN_W(256), .OUT_W(119), .NUM_VEC(NB), .LAT(LB), .ZERO_EVERY(4),
                       .SEED(SEED), .POLY(POLY)) u_b (
    .clk(clk), .rst(rst_bc), .start(start_b), .stim(stim_b), .y_ref(y_ref_b), .y_dut(y_dut_b),
    .busy(busy_b), .done(done_b), .mismatch(mis_b), .first_idx(first_b), .mis_count(cnt_b),
    .signature(sig_b));

  // ---------------- instance C: long run, y_dut = ~y_ref ----------------
  logic start_c = 1'b0;
  logic [63:0] stim_c;
  logic [39:0] y_ref_c, y_dut_c;
  logic busy_c, done_c, mis_c;
  logic [15:0] first_c, cnt_c;
  logic [31:0] sig_c;
  int c_c = 1000;
  bit go_c = 0, act_c = 0;
  res_t res_qc [$];
  res_t e_c;

  always @(posedge clk) c_c <= go_c ? 0 : (c_c < 1000000 ? c_c + 1 : c_c);
  assign y_ref_c = 40'(gold({192'h0, stim_c}));
  assign y_dut_c = ~y_ref_c;

  equiv_stim_checker #(.IN_W(64), .OUT_W(40), .NUM_VEC(NC), .LAT(1), .ZERO_EVERY(0),
                       .SEED(SEED), .POLY(POLY)) u_c (
    .clk(clk), .rst(rst_bc), .start(start_c), .stim(stim_c), .y_ref(y_ref_c), .y_dut(y_dut_c),
    .busy(busy_c), .done(done_c), .mismatch(mis_c), .first_idx(first_c), .mis_count(cnt_c),
    .signature(sig_c));

  // ---------------- reference model ----------------
  // mode: 0 y_dut==y_ref, 1 y_dut=y_ref^mask_a[k], 2 y_dut=y of previous stim, 3 y_dut=~y_ref
  task automatic model_run(input int inst, input int in_w, input int out_w, input int n,
                           input int ze, input int mode, output res_t r);
    logic [31:0] l [8];
    logic [255:0] v, prev, ym, yr, yd, inmask;
    logic [31:0] fold;
    inmask = (256'(1) << in_w) - 256'(1);
    ym = (256'(1) << out_w) - 256'(1);
    for (int i = 0; i < 8; i++) l[i] = SEED ^ (32'(i) * 32'h9E3779B9);
    r = '0;
    r.first = 16'hFFFF;
    prev = '0;
    for (int k = 0; k < n; k++) begin
      if (ze > 0 && (k % ze) == ze - 1) begin
        v = '0;
      end else begin
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = l[i];
        v = v & inmask;
        for (int i = 0; i < 8; i++) l[i] = step(l[i]);
      end
      if (inst == 0) exp_stim_a.push_back(v);
      if (inst == 1) exp_stim_b.push_back(v);
      yr = gold(v) & ym;
      case (mode)
        1: yd = yr ^ 256'(mask_a[k]);
        2: yd = gold(prev) & ym;
        3: yd = ~yr & ym;
        default: yd = yr;
      endcase
      if (yd != yr) begin
        if (!r.mis) begin
          r.mis = 1'b1;
          r.first = 16'(k);
        end
        if (r.cnt != 16'hFFFF) r.cnt = r.cnt + 16'h1;
      end
      fold = '0;
      for (int i = 0; i < 8; i++) fold = fold ^ yd[i*32 +: 32];
      r.sig = step(r.sig) ^ fold;
      prev = v;
    end
  endtask

  // ---------------- stimulus tasks ----------------
  task automatic run_a(input int mode);
    res_t r;
    exp_stim_a.delete();
    model_run(0, 256, 119, NA, 0, mode, r);
    res_qa.push_back(r);
    @(negedge clk); start_a = 1'b1; go_a = 1'b1;
    @(posedge clk); act_a = 1'b1;
    @(negedge clk); start_a = 1'b0; go_a = 1'b0;
  endtask

  task automatic run_b();
    res_t r;
    exp_stim_b.delete();
    model_run(1, 256, 119, NB, 4, 2, r);
    res_qb.push_back(r);
    @(negedge clk); start_b = 1'b1; go_b = 1'b1;
    @(posedge clk); act_b = 1'b1;
    @(negedge clk); start_b = 1'b0; go_b = 1'b0;
  endtask

  task automatic run_c();
    res_t r;
    model_run(2, 64, 40, NC, 0, 3, r);
    res_qc.push_back(r);
    @(negedge clk); start_c = 1'b1; go_c = 1'b1;
    @(posedge clk); act_c = 1'b1;
    @(negedge clk); start_c = 1'b0; go_c = 1'b0;
  endtask

  task automatic wait_run(input int which, input int budget);
    int n;
    bit still;
    n = 0;
    still = 1'b1;
    while (still && n < budget) begin
      @(negedge clk);
      n++;
      still = (which == 0) ? act_a : (which == 1) ? act_b : act_c;
    end
    if (still) begin
      $display("FAIL timeout_waiting_done inst=%0d budget=%0d", which, budget);
      checks++;
      failures++;
      if (which == 0) act_a = 1'b0; else if (which == 1) act_b = 1'b0; else act_c = 1'b0;
    end
  endtask

  task automatic reset_check_a(input string nm);
    chk({nm, "_stim"}, stim_a, '0);
    chk({nm, "_busy"}, busy_a, 0);
    chk({nm, "_done"}, done_a, 0);
    chk({nm, "_mismatch"}, mis_a, 0);
    chk({nm, "_first_idx"}, first_a, 16'hFFFF);
    chk({nm, "_mis_count"}, cnt_a, 0);
    chk({nm, "_signature"}, sig_a, 0);
  endtask

  task automatic random_masks();
    for (int k = 0; k < NA; k++)
      mask_a[k] = ($urandom_range(0, 3) == 0) ?
                  119'({$urandom(), $urandom(), $urandom(), $urandom()}) : '0;
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (act_a) begin
      if (c_a <= 1) chk("a_prime_stim", stim_a, '0);
      else if (c_a < NA + 2) begin
        if (exp_stim_a.size() == 0) fail_now("a_stim_queue_empty");
        else chk("a_stim", stim_a, exp_stim_a.pop_front());
      end
      if (done_a) begin
        if (res_qa.size() == 0) fail_now("a_result_queue_empty");
        else begin
          e_a = res_qa.pop_front();
          chk("a_done_cycle", 256'(c_a), 256'(1 + NA + 1));
          chk("a_busy_at_done", busy_a, 0);
          chk("a_mismatch", mis_a, e_a.mis);
          chk("a_first_idx", first_a, e_a.first);
          chk("a_mis_count", cnt_a, e_a.cnt);
          chk("a_signature", sig_a, e_a.sig);
          last_a = e_a;
        end
        act_a = 1'b0;
      end else chk("a_busy", busy_a, 1);
    end
  end

  always @(negedge clk) begin
    if (act_b) begin
      if (c_b >= 2 && c_b < NB + 2) begin
        if (exp_stim_b.size() == 0) fail_now("b_stim_queue_empty");
        else chk("b_stim", stim_b, exp_stim_b.pop_front());
        if (((c_b - 2) % 4) == 3) chk("b_zero_vector", stim_b, '0);
        if (c_b == 6) chk("b_k4_equals_plain_k3", stim_b, plain_vec(3));
      end
      if (done_b) begin
        if (res_qb.size() == 0) fail_now("b_result_queue_empty");
        else begin
          e_b = res_qb.pop_front();
          chk("b_done_cycle", 256'(c_b), 256'(1 + NB + LB));
          chk("b_mismatch", mis_b, e_b.mis);
          chk("b_first_idx", first_b, e_b.first);
          chk("b_mis_count", cnt_b, e_b.cnt);
          chk("b_signature", sig_b, e_b.sig);
        end
        act_b = 1'b0;
      end else chk("b_busy", busy_b, 1);
    end
  end

  always @(negedge clk) begin
    if (act_c && done_c) begin
      if (res_qc.size() == 0) fail_now("c_result_queue_empty");
      else begin
        e_c = res_qc.pop_front();
        chk("c_done_cycle", 256'(c_c), 256'(1 + NC + 1));
        chk("c_mismatch", mis_c, 1);
        chk("c_first_idx", first_c, 0);
        chk("c_mis_count_saturated", cnt_c, 16'hFFFF);
        chk("c_signature", sig_c, e_c.sig);
      end
      act_c = 1'b0;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    for (int k = 0; k < NA; k++) mask_a[k] = '0;
    repeat (3) @(negedge clk);
    reset_check_a("a_reset");
    chk("b_reset_first_idx", first_b, 16'hFFFF);
    chk("c_reset_stim", stim_c, '0);
    rst_a = 1'b0;
    rst_bc = 1'b0;
    fork
      begin
        run_c();
        wait_run(2, NC + 100);
      end
      begin
        run_b();
        wait_run(1, 200);
        repeat (2) @(negedge clk);
        run_b();
        wait_run(1, 200);
      end
      begin
        run_a(0);
        wait_run(0, 200);
        repeat (3) @(negedge clk);
        chk("a_hold_done", done_a, 1);
        chk("a_hold_signature", sig_a, last_a.sig);
        chk("a_hold_mis_count", cnt_a, last_a.cnt);
        mask_a[5] = 119'h1;
        run_a(1);
        wait_run(0, 200);
        for (int r = 0; r < 3; r++) begin
          random_masks();
          run_a(1);
          if (r == 1) begin
            for (int n = 0; n < 50 && c_a != 8; n++) @(negedge clk);
            start_a = 1'b1;
            @(negedge clk);
            start_a = 1'b0;
          end
          wait_run(0, 200);
        end
        random_masks();
        run_a(1);
        for (int n = 0; n < 50 && c_a != 12; n++) @(negedge clk);
        rst_a = 1'b1;
        act_a = 1'b0;
        res_qa.delete();
        @(negedge clk);
        rst_a = 1'b0;
        reset_check_a("a_midrun_reset");
        run_a(1);
        wait_run(0, 200);
      end
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
